// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA fetch > full-FIFO drain > CPU read > drain; VGA/CPU read latency 2.
// VGA never stalls; CPU writes are buffered (cpu_wr_full stalls), CPU reads hold cpu_rd_req until cpu_rd_valid.
module fb_port_arbiter #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 8,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_rd_req,
    input  logic [ADDR_W-1:0] vga_rd_addr,
    output logic              vga_rd_valid,
    output logic [DATA_W-1:0] vga_rd_data,
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_rd_addr,
    output logic              cpu_rd_valid,
    output logic [DATA_W-1:0] cpu_rd_data,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_wr_full,
    output logic              wr_overflow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_BUSY} rd_state_t;

    logic [ADDR_W-1:0] fifo_addr_q [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [WFIFO_DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;

    rd_state_t         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              fwd1_q, fwd2_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic              tag1_vga_q, tag1_cpu_q, tag2_vga_q, tag2_cpu_q;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;

    logic              full, push, accept, fwd_hit, cpu_want, drain, gnt_cpu;
    logic [DATA_W-1:0] fwd_val;
    logic [ADDR_W-1:0] cpu_addr_sel;

    assign full     = (count_q == CNT_W'(WFIFO_DEPTH));
    assign push     = cpu_wr_en && !full;
    assign accept   = (rd_state_q == RD_IDLE) && cpu_rd_req;
    assign cpu_want = (accept && !fwd_hit) || (rd_state_q == RD_WAIT);
    assign drain    = !vga_rd_req && (count_q != '0) && (full || !cpu_want);
    assign gnt_cpu  = !vga_rd_req && !full && cpu_want;
    assign cpu_addr_sel = (rd_state_q == RD_WAIT) ? rd_addr_q : cpu_rd_addr;

    // Scan oldest to youngest so the last match wins; a dropped (full) write is never forwarded.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_val = '0;
        for (int i = 0; i < WFIFO_DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (fifo_addr_q[head_q + PTR_W'(i)] == cpu_rd_addr)) begin
                fwd_hit = 1'b1;
                fwd_val = fifo_data_q[head_q + PTR_W'(i)];
            end
        end
        if (push && (cpu_wr_addr == cpu_rd_addr)) begin
            fwd_hit = 1'b1;
            fwd_val = cpu_wr_data;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (cpu_rd_req) rd_state_d = (fwd_hit || gnt_cpu) ? RD_BUSY : RD_WAIT;
            RD_WAIT: if (gnt_cpu) rd_state_d = RD_BUSY;
            RD_BUSY: if (cpu_rd_valid) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if (vga_rd_req) begin
            mem_addr_d = vga_rd_addr;
        end else if (drain) begin
            mem_addr_d  = fifo_addr_q[head_q];
            mem_wdata_d = fifo_data_q[head_q];
            mem_we_d    = 1'b1;
        end else if (gnt_cpu) begin
            mem_addr_d = cpu_addr_sel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WFIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            rd_state_q  <= RD_IDLE;
            rd_addr_q   <= '0;
            fwd1_q      <= 1'b0;
            fwd2_q      <= 1'b0;
            fwd_data_q  <= '0;
            tag1_vga_q  <= 1'b0;
            tag1_cpu_q  <= 1'b0;
            tag2_vga_q  <= 1'b0;
            tag2_cpu_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            if (push) begin
                fifo_addr_q[tail_q] <= cpu_wr_addr;
                fifo_data_q[tail_q] <= cpu_wr_data;
                tail_q              <= tail_q + PTR_W'(1);
            end
            if (drain) head_q <= head_q + PTR_W'(1);
            case ({push, drain})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            overflow_q <= overflow_q | (cpu_wr_en & full);
            rd_state_q <= rd_state_d;
            if (accept) rd_addr_q <= cpu_rd_addr;
            fwd1_q <= accept && fwd_hit;
            fwd2_q <= fwd1_q;
            if (accept && fwd_hit) fwd_data_q <= fwd_val;
            tag1_vga_q  <= vga_rd_req;
            tag1_cpu_q  <= gnt_cpu;
            tag2_vga_q  <= tag1_vga_q;
            tag2_cpu_q  <= tag1_cpu_q;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign cpu_wr_full  = full;
    assign wr_overflow  = overflow_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_we       = mem_we_q;
    assign vga_rd_valid = tag2_vga_q;
    assign vga_rd_data  = tag2_vga_q ? mem_rdata : '0;
    assign cpu_rd_valid = tag2_cpu_q | fwd2_q;
    assign cpu_rd_data  = tag2_cpu_q ? mem_rdata : (fwd2_q ? fwd_data_q : '0);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: directed scenarios plus randomized traffic against a queue-based reference.
module tb_fb_port_arbiter;
    localparam int AW = 19;
    localparam int DW = 8;
    localparam int D  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          vga_rd_req, vga_rd_valid;
    logic [AW-1:0] vga_rd_addr;
    logic [DW-1:0] vga_rd_data;
    logic          cpu_rd_req, cpu_rd_valid;
    logic [AW-1:0] cpu_rd_addr;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_wr_en, cpu_wr_full, wr_overflow;
    logic [AW-1:0] cpu_wr_addr;
    logic [DW-1:0] cpu_wr_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we;

    always #5 clock = ~clock;

    fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(D)) dut (
        .clock(clock), .reset(reset),
        .vga_rd_req(vga_rd_req), .vga_rd_addr(vga_rd_addr),
        .vga_rd_valid(vga_rd_valid), .vga_rd_data(vga_rd_data),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
        .cpu_wr_en(cpu_wr_en), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_wr_full(cpu_wr_full), .wr_overflow(wr_overflow),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Untouched RAM locations read back as a fixed function of address.
    function automatic logic [7:0] init_val(input logic [AW-1:0] a);
        return a[7:0] + 8'h91;
    endfunction

    logic [7:0] ram [int];
    always @(posedge clock) begin
        mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : init_val(mem_addr);
        if (mem_we) ram[int'(mem_addr)] = mem_wdata;
    end

    int checks = 0;
    int failures = 0;
    int we_cnt = 0;
    int vv_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: write queue in program order, plus the RAM image as it will look once drains land.
    logic [AW-1:0] mq_a [$];
    logic [7:0]    mq_d [$];
    logic [7:0]    mram [int];
    int            m_rd = 0;          // 0 idle, 1 accepted awaiting RAM, 2 result scheduled
    logic [AW-1:0] m_rd_addr = '0;
    logic          vp1 = 0, vp2 = 0, cp1 = 0, cp2 = 0, m_we = 0, m_ovf = 0;
    logic [7:0]    vd1 = 0, vd2 = 0, cd1 = 0, cd2 = 0, m_wdata = 0;
    logic [AW-1:0] m_waddr = '0;

    function automatic logic [7:0] mram_rd(input logic [AW-1:0] a);
        return mram.exists(int'(a)) ? mram[int'(a)] : init_val(a);
    endfunction

    function automatic logic [7:0] arch_rd(input logic [AW-1:0] a);
        logic [7:0] v = mram_rd(a);
        foreach (mq_a[i]) if (mq_a[i] == a) v = mq_d[i];
        return v;
    endfunction

    task automatic model();
        logic full, push, accept, hit, want, dr, cg;
        logic [7:0] hd, n_cd;
        if (reset) begin
            mq_a.delete(); mq_d.delete();
            m_rd = 0; vp1 = 0; vp2 = 0; cp1 = 0; cp2 = 0; m_we = 0; m_ovf = 0;
            return;
        end
        full   = (mq_a.size() == D);
        push   = cpu_wr_en && !full;
        if (cpu_wr_en && full) m_ovf = 1;
        accept = (m_rd == 0) && cpu_rd_req;
        hit = 0; hd = 0;
        if (accept) begin
            foreach (mq_a[i]) if (mq_a[i] == cpu_rd_addr) begin hit = 1; hd = mq_d[i]; end
            if (push && cpu_wr_addr == cpu_rd_addr) begin hit = 1; hd = cpu_wr_data; end
        end
        want = (accept && !hit) || (m_rd == 1);
        dr   = !vga_rd_req && mq_a.size() > 0 && (full || !want);
        cg   = !vga_rd_req && !full && want;
        n_cd = hit ? hd : mram_rd(accept ? cpu_rd_addr : m_rd_addr);
        vp2 = vp1; vd2 = vd1;
        vp1 = vga_rd_req; vd1 = vga_rd_req ? mram_rd(vga_rd_addr) : 8'h00;
        m_we = dr;
        if (dr) begin
            m_waddr = mq_a.pop_front();
            m_wdata = mq_d.pop_front();
            mram[int'(m_waddr)] = m_wdata;
        end
        if (push) begin mq_a.push_back(cpu_wr_addr); mq_d.push_back(cpu_wr_data); end
        if (accept) begin
            m_rd_addr = cpu_rd_addr;
            m_rd = (hit || cg) ? 2 : 1;
        end else if (m_rd == 1 && cg) m_rd = 2;
        else if (m_rd == 2 && cp2) m_rd = 0;
        cp2 = cp1; cd2 = cd1;
        cp1 = hit || cg; cd1 = n_cd;
    endtask

    task automatic cyc();
        @(posedge clock);
        model();
        @(negedge clock);
        if (mem_we) we_cnt++;
        if (vga_rd_valid) vv_cnt++;
        chk("vga_valid", 32'(vga_rd_valid), 32'(vp2));
        if (vp2) chk("vga_data", 32'(vga_rd_data), 32'(vd2));
        chk("cpu_valid", 32'(cpu_rd_valid), 32'(cp2));
        if (cp2) chk("cpu_data", 32'(cpu_rd_data), 32'(cd2));
        chk("wr_full", 32'(cpu_wr_full), 32'(mq_a.size() == D));
        chk("overflow", 32'(wr_overflow), 32'(m_ovf));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        if (m_we) begin
            chk("mem_waddr", 32'(mem_addr), 32'(m_waddr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        end
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
        logic got = 0;
        logic [7:0] rd = 0;
        cpu_rd_req = 1; cpu_rd_addr = a;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            if (cpu_rd_valid) begin got = 1; rd = cpu_rd_data; end
        end
        cpu_rd_req = 0;
        chk({tag, "_done"}, 32'(got), 1);
        if (got) chk(tag, 32'(rd), 32'(exp));
        cyc();
    endtask

    initial begin
        reset = 1; vga_rd_req = 0; vga_rd_addr = '0; cpu_rd_req = 0; cpu_rd_addr = '0;
        cpu_wr_en = 0; cpu_wr_addr = '0; cpu_wr_data = '0;
        cyc(); cyc();
        chk("rst_vga_valid", 32'(vga_rd_valid), 0);
        chk("rst_cpu_valid", 32'(cpu_rd_valid), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_full", 32'(cpu_wr_full), 0);
        chk("rst_ovf", 32'(wr_overflow), 0);
        reset = 0;

        // Pipelined VGA fetches, fixed latency 2
        vga_rd_req = 1; vga_rd_addr = 19'h00010; cyc();
        vga_rd_addr = 19'h00011; cyc();
        chk("vga0_valid", 32'(vga_rd_valid), 1); chk("vga0_data", 32'(vga_rd_data), 'hA1);
        vga_rd_addr = 19'h00012; cyc();
        chk("vga1_data", 32'(vga_rd_data), 'hA2);
        vga_rd_req = 0; cyc();
        chk("vga2_data", 32'(vga_rd_data), 'hA3);
        cyc();
        chk("vga_end_valid", 32'(vga_rd_valid), 0);

        // FIFO fills behind continuous VGA traffic, one gap drains the oldest entry
        vga_rd_req = 1; vga_rd_addr = 19'h00020; we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_wr_en = 1; cpu_wr_addr = AW'(32'h300 + i); cpu_wr_data = DW'(8'h10 + i); cyc();
        end
        cpu_wr_en = 0;
        chk("fill_full", 32'(cpu_wr_full), 1);
        chk("fill_no_we", 32'(we_cnt), 0);
        vga_rd_req = 0; cyc();
        chk("gap_we", 32'(mem_we), 1);
        chk("gap_addr", 32'(mem_addr), 'h300);
        chk("gap_wdata", 32'(mem_wdata), 'h10);
        chk("gap_full", 32'(cpu_wr_full), 0);
        vga_rd_req = 1; cyc(); cyc();
        chk("gap_one_we", 32'(we_cnt), 1);
        vga_rd_req = 0; repeat (5) cyc();

        // Youngest buffered write is forwarded; the RAM slot goes to a drain instead
        vga_rd_req = 1;
        cpu_wr_en = 1; cpu_wr_addr = 19'h00100; cpu_wr_data = 8'h55; cyc();
        cpu_wr_data = 8'h66; cyc();
        cpu_wr_en = 0; vga_rd_req = 0; cpu_rd_req = 1; cpu_rd_addr = 19'h00100; cyc();
        chk("fwd_slot_drain", 32'(mem_we), 1);
        chk("fwd_not_yet", 32'(cpu_rd_valid), 0);
        cyc();
        chk("fwd_valid", 32'(cpu_rd_valid), 1); chk("fwd_data", 32'(cpu_rd_data), 'h66);
        cpu_rd_req = 0; repeat (3) cyc();

        // Same-cycle write is ordered before the read
        cpu_wr_en = 1; cpu_wr_addr = 19'h00200; cpu_wr_data = 8'h7E;
        cpu_rd_req = 1; cpu_rd_addr = 19'h00200; cyc();
        cpu_wr_en = 0; cyc();
        chk("same_valid", 32'(cpu_rd_valid), 1); chk("same_data", 32'(cpu_rd_data), 'h7E);
        cpu_rd_req = 0; cyc(); cyc();

        // Overflow: fifth write dropped, flag sticky
        vga_rd_req = 1;
        for (int i = 0; i < 5; i++) begin
            cpu_wr_en = 1; cpu_wr_addr = AW'(32'h310 + i); cpu_wr_data = DW'(8'hC0 + i); cyc();
        end
        cpu_wr_en = 0;
        chk("ovf_set", 32'(wr_overflow), 1);
        chk("ovf_full", 32'(cpu_wr_full), 1);
        vga_rd_req = 0; repeat (6) cyc();
        chk("ovf_sticky", 32'(wr_overflow), 1);
        do_read("ovf_dropped", 19'h00314, 8'hA5);
        do_read("ovf_kept", 19'h00313, 8'hC3);

        // Reset with a VGA fetch in flight and three buffered writes
        vga_rd_req = 1; vga_rd_addr = 19'h00010;
        for (int i = 0; i < 3; i++) begin
            cpu_wr_en = 1; cpu_wr_addr = AW'(32'h400 + i); cpu_wr_data = DW'(8'h30 + i); cyc();
        end
        cpu_wr_en = 0; reset = 1; cyc();
        chk("mid_rst_vga", 32'(vga_rd_valid), 0);
        chk("mid_rst_full", 32'(cpu_wr_full), 0);
        chk("mid_rst_ovf", 32'(wr_overflow), 0);
        reset = 0; vga_rd_req = 0; we_cnt = 0; vv_cnt = 0;
        repeat (6) cyc();
        chk("mid_rst_no_we", 32'(we_cnt), 0);
        chk("mid_rst_no_vga", 32'(vv_cnt), 0);
        do_read("mid_rst_lost", 19'h00401, 8'h92);

        // Randomized mixed traffic
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            vga_rd_req  = ($urandom_range(0, 99) < 55);
            vga_rd_addr = $urandom_range(0, 1) ? AW'(32'h100 + $urandom_range(0, 7)) : AW'($urandom_range(0, 15));
            cpu_wr_en   = ($urandom_range(0, 99) < 35);
            cpu_wr_addr = AW'(32'h100 + $urandom_range(0, 7));
            cpu_wr_data = DW'($urandom);
            if (cpu_rd_req && cpu_rd_valid) cpu_rd_req = 0;
            else if (!cpu_rd_req && $urandom_range(0, 3) == 0) begin
                cpu_rd_req = 1; cpu_rd_addr = AW'(32'h100 + $urandom_range(0, 7));
            end
            cyc();
        end
        reset = 0; vga_rd_req = 0; cpu_wr_en = 0;
        repeat (10) begin
            if (cpu_rd_req && cpu_rd_valid) cpu_rd_req = 0;
            cyc();
        end
        cpu_rd_req = 0; cyc();
        for (int a = 0; a < 8; a++) do_read("readback", AW'(32'h100 + a), arch_rd(AW'(32'h100 + a)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Single-port frame-buffer arbiter between the VGA pixel-fetch path, processor frame-buffer reads and processor frame-buffer writes. Owns the only address/data port of the synchronous 8-bit-index frame-buffer RAM and grants one access per cycle. Buffers processor writes in a small FIFO so the processor rarely stalls. Forwards buffered write data to processor reads so read-after-write ordering holds.

## Interface
- ADDR_W, 19, frame-buffer address width (matches vga_address)
- DATA_W, 8, palette-index width (matches vga_index)
- WFIFO_DEPTH, 4, processor write FIFO entries (power of 2, ≥2)

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- vga_rd_req  in  1  one pixel fetch per asserted cycle
- vga_rd_addr  in  ADDR_W  fetch address
- vga_rd_valid  out  1  fetch data valid
- vga_rd_data  out  DATA_W  fetched index
- cpu_rd_req  in  1  level; held until cpu_rd_valid
- cpu_rd_addr  in  ADDR_W  held stable with cpu_rd_req
- cpu_rd_valid  out  1  one-cycle pulse, read complete
- cpu_rd_data  out  DATA_W  read result
- cpu_wr_en  in  1  enqueue write this cycle
- cpu_wr_addr  in  ADDR_W  write address
- cpu_wr_data  in  DATA_W  write data
- cpu_wr_full  out  1  FIFO full; processor must stall writes
- wr_overflow  out  1  sticky: cpu_wr_en seen while full
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_rdata  in  DATA_W  RAM read data, valid cycle after mem_addr presented

## Operation
- Grant per cycle N, highest first: (1) vga_rd_req; (2) write drain if FIFO full; (3) cpu_rd_req not already in flight and not forwarded; (4) write drain if FIFO non-empty; (5) idle (mem_we=0, mem_addr holds).
- VGA is never stalled; the display path's blanking intervals supply idle slots for drain.
- Write FIFO: circular, head/tail pointers plus count (0..WFIFO_DEPTH). Push on cpu_wr_en && !cpu_wr_full; pop on drain grant. Push and pop in the same cycle: count unchanged. cpu_wr_en while full: write dropped, wr_overflow set until reset.
- cpu_wr_full = (count == WFIFO_DEPTH), combinational from count; a pop in the same cycle does not free the slot for a same-cycle push.
- Forwarding: at the cycle cpu_rd_req is first accepted, compare cpu_rd_addr with every valid FIFO entry and with same-cycle cpu_wr_addr when cpu_wr_en is asserted. A same-cycle write is ordered before the read. The youngest match supplies the data and no RAM access is made. With no match, the read arbitrates for the RAM.
- One processor read in flight at a time. cpu_rd_req is ignored from acceptance until cpu_rd_valid. A new read is accepted no earlier than the cycle after the valid pulse.
- Tag pipeline: a 2-stage shift register of {vga, cpu} tags steers mem_rdata to the requester.

## Timing
- Reset values: vga_rd_valid=0, cpu_rd_valid=0, rd data=0, mem_we=0, mem_addr=0, mem_wdata=0, FIFO count=0, cpu_wr_full=0, wr_overflow=0, tags cleared.
- VGA fetch: request in cycle N → mem_addr in N+1 → vga_rd_valid with vga_rd_data=mem_rdata in N+2. Fixed latency 2. Fully pipelined, one result per cycle.
- CPU read granted in cycle N: cpu_rd_valid in N+2. Forwarded read accepted in N: cpu_rd_valid in N+2, with data captured at end of N.
- Write drained in cycle N: mem_we=1 in N+1 only.
- Reset asserted mid-operation: in-flight reads are discarded (no valid pulse) and buffered writes are lost. Outputs take reset values on the next edge.

## Test plan
- Reset, then vga_rd_req on 3 consecutive cycles to 0x00010, 0x00011, 0x00012 with RAM preloaded 0xA1, 0xA2, 0xA3 → vga_rd_valid on cycles 2, 3, 4 carrying 0xA1, 0xA2, 0xA3.
- 4 writes with vga_rd_req held high → cpu_wr_full=1, zero mem_we. Drop vga_rd_req one cycle → exactly one mem_we=1 for the oldest entry; full then deasserts.
- Write 0x100←0x55 then 0x100←0x66 while VGA is busy. cpu_rd_req 0x100 → cpu_rd_valid 2 cycles later with 0x66 and no RAM read issued.
- Same-cycle cpu_wr_en 0x200←0x7E and cpu_rd_req 0x200 → cpu_rd_data=0x7E.
- Full FIFO plus cpu_wr_en → write dropped and wr_overflow=1, which stays set until reset.
- Reset during an in-flight VGA read and with 3 buffered writes → no valid pulse, no later mem_we, cpu_wr_full=0.
